// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, ALUOp codes, mux selects, states.
// Optional feature macro: MC_JUMP_EN (adds the JUMP state for op 0x02).
package mips_ctrl_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned ST_W     = 4;
   localparam int unsigned ALUOP_W  = 3;
   localparam int unsigned SEL_W    = 2;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b100;
   localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b111;
   localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b101;
   localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b110;
   localparam logic [ALUOP_W-1:0] ALU_LUI   = 3'b010;

   localparam logic [SEL_W-1:0] SRCB_RT      = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;

   typedef logic [ST_W-1:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEM_ADDR = 4'd2;
   localparam state_t S_MEM_RD   = 4'd3;
   localparam state_t S_MEM_WB   = 4'd4;
   localparam state_t S_MEM_WR   = 4'd5;
   localparam state_t S_R_EXEC   = 4'd6;
   localparam state_t S_R_WB     = 4'd7;
   localparam state_t S_I_EXEC   = 4'd8;
   localparam state_t S_I_WB     = 4'd9;
   localparam state_t S_BRANCH   = 4'd10;
   localparam state_t S_TRAP     = 4'd11;
`ifdef MC_JUMP_EN
   localparam state_t S_JUMP     = 4'd12;
   localparam logic [SEL_W-1:0] PCSRC_JUMP = 2'b10;
`endif

   // Control word driven by the output decoder.
   typedef struct packed {
      logic                pc_write;
      logic                pc_write_eq;
      logic                pc_write_ne;
      logic                i_or_d;
      logic                mem_read;
      logic                mem_write;
      logic                ir_write;
      logic                mem_to_reg;
      logic                reg_dst;
      logic                reg_write;
      logic                alu_src_a;
      logic [SEL_W-1:0]    alu_src_b;
      logic [ALUOP_W-1:0]  alu_op;
      logic [SEL_W-1:0]    pc_source;
      logic                instr_done;
   } ctrl_t;

   // State that follows DECODE for a given opcode; unsupported opcodes trap.
   function automatic state_t decode_next(input logic [OP_W-1:0] op);
      case (op)
         OP_LW, OP_SW:                     decode_next = S_MEM_ADDR;
         OP_RTYPE:                         decode_next = S_R_EXEC;
         OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: decode_next = S_I_EXEC;
         OP_BEQ, OP_BNE:                   decode_next = S_BRANCH;
`ifdef MC_JUMP_EN
         OP_J:                             decode_next = S_JUMP;
`else
         OP_J:                             decode_next = S_TRAP;
`endif
         default:                          decode_next = S_TRAP;
      endcase
   endfunction

   // ALU operation for the immediate-type instructions.
   function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [OP_W-1:0] op);
      case (op)
         OP_ANDI: imm_alu_op = ALU_AND;
         OP_ORI:  imm_alu_op = ALU_OR;
         OP_LUI:  imm_alu_op = ALU_LUI;
         default: imm_alu_op = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Pure combinational control-word decode from (state, op, mem_ready, reset).
// Optional feature macro: MC_JUMP_EN (decodes the JUMP state).
module mc_output_decode
   import mips_ctrl_pkg::*;
(
   input  state_t            i_state,
   input  logic [OP_W-1:0]   i_op,
   input  logic              i_mem_ready,
   input  logic              i_reset,
   output ctrl_t             o_ctrl
);

   // Reset forces every strobe low, which also abandons any in-flight access.
   always_comb begin
      o_ctrl = '0;
      if (!i_reset) begin
         case (i_state)
            S_FETCH: begin
               o_ctrl.mem_read  = 1'b1;
               o_ctrl.i_or_d    = 1'b0;
               o_ctrl.alu_src_a = 1'b0;
               o_ctrl.alu_src_b = SRCB_FOUR;
               o_ctrl.alu_op    = ALU_ADD;
               o_ctrl.pc_source = PCSRC_ALU;
               o_ctrl.ir_write  = i_mem_ready;
               o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
               o_ctrl.alu_src_a = 1'b0;
               o_ctrl.alu_src_b = SRCB_IMM_SH2;
               o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
               o_ctrl.alu_src_a = 1'b1;
               o_ctrl.alu_src_b = SRCB_IMM;
               o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
               o_ctrl.mem_read = 1'b1;
               o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               o_ctrl.reg_write  = 1'b1;
               o_ctrl.mem_to_reg = 1'b1;
               o_ctrl.reg_dst    = 1'b0;
               o_ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
               o_ctrl.mem_write  = 1'b1;
               o_ctrl.i_or_d     = 1'b1;
               o_ctrl.instr_done = i_mem_ready;
            end
            S_R_EXEC: begin
               o_ctrl.alu_src_a = 1'b1;
               o_ctrl.alu_src_b = SRCB_RT;
               o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
               o_ctrl.reg_write  = 1'b1;
               o_ctrl.reg_dst    = 1'b1;
               o_ctrl.mem_to_reg = 1'b0;
               o_ctrl.instr_done = 1'b1;
            end
            S_I_EXEC: begin
               o_ctrl.alu_src_a = 1'b1;
               o_ctrl.alu_src_b = SRCB_IMM;
               o_ctrl.alu_op    = imm_alu_op(i_op);
            end
            S_I_WB: begin
               o_ctrl.reg_write  = 1'b1;
               o_ctrl.reg_dst    = 1'b0;
               o_ctrl.mem_to_reg = 1'b0;
               o_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
               o_ctrl.alu_src_a   = 1'b1;
               o_ctrl.alu_src_b   = SRCB_RT;
               o_ctrl.alu_op      = ALU_SUB;
               o_ctrl.pc_source   = PCSRC_ALUOUT;
               o_ctrl.instr_done  = 1'b1;
               o_ctrl.pc_write_eq = (i_op == OP_BEQ);
               o_ctrl.pc_write_ne = (i_op == OP_BNE);
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
               o_ctrl.pc_write   = 1'b1;
               o_ctrl.pc_source  = PCSRC_JUMP;
               o_ctrl.instr_done = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and sticky illegal_op flag.
// Optional feature macro: MC_JUMP_EN (op 0x02 executes as a jump instead of trapping).
module multicycle_control
   import mips_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [OP_W-1:0]     op,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_eq,
   output logic                pc_write_ne,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [SEL_W-1:0]    alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [SEL_W-1:0]    pc_source,
   output logic                instr_done,
   output logic                illegal_op
);

   state_t r_state;
   state_t w_next_state;
   logic   r_illegal_op;
   ctrl_t  w_ctrl;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_FETCH;
         r_illegal_op <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_DECODE && w_next_state == S_TRAP)
            r_illegal_op <= 1'b1;
      end
   end

   // Memory states wait on mem_ready; TRAP holds until reset.
   always_comb begin
      w_next_state = S_FETCH;
      case (r_state)
         S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   w_next_state = decode_next(op);
         S_MEM_ADDR: w_next_state = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   w_next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB:   w_next_state = S_FETCH;
         S_MEM_WR:   w_next_state = mem_ready ? S_FETCH : S_MEM_WR;
         S_R_EXEC:   w_next_state = S_R_WB;
         S_R_WB:     w_next_state = S_FETCH;
         S_I_EXEC:   w_next_state = S_I_WB;
         S_I_WB:     w_next_state = S_FETCH;
         S_BRANCH:   w_next_state = S_FETCH;
`ifdef MC_JUMP_EN
         S_JUMP:     w_next_state = S_FETCH;
`endif
         S_TRAP:     w_next_state = S_TRAP;
         default:    w_next_state = S_FETCH;
      endcase
   end

   mc_output_decode u_output_decode (
      .i_state     (r_state),
      .i_op        (op),
      .i_mem_ready (mem_ready),
      .i_reset     (reset),
      .o_ctrl      (w_ctrl)
   );

   assign pc_write    = w_ctrl.pc_write;
   assign pc_write_eq = w_ctrl.pc_write_eq;
   assign pc_write_ne = w_ctrl.pc_write_ne;
   assign i_or_d      = w_ctrl.i_or_d;
   assign mem_read    = w_ctrl.mem_read;
   assign mem_write   = w_ctrl.mem_write;
   assign ir_write    = w_ctrl.ir_write;
   assign mem_to_reg  = w_ctrl.mem_to_reg;
   assign reg_dst     = w_ctrl.reg_dst;
   assign reg_write   = w_ctrl.reg_write;
   assign alu_src_a   = w_ctrl.alu_src_a;
   assign alu_src_b   = w_ctrl.alu_src_b;
   assign alu_op      = w_ctrl.alu_op;
   assign pc_source   = w_ctrl.pc_source;
   assign instr_done  = w_ctrl.instr_done;
   assign illegal_op  = r_illegal_op & ~reset;

endmodule
